image_rx_writer: RTL
====================

IMAGE_RX_WRITER -- requirements
Module: image_rx_writer

Interface
REQ-001 Parameter IMG_W, default 512, image width in pixels.
REQ-002 Parameter IMG_H, default 392, image height in lines.
REQ-003 Parameter ADDR_W, default 18, write-address width; IMG_W*IMG_H SHALL be at most 2**ADDR_W.
REQ-004 Parameter TIMEOUT_CYC, default 100000, idle clocks allowed inside a partial pixel before it is discarded.
REQ-005 clk  in  1  single clock for all logic (the 100 MHz system domain).
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rx_ready  in  1  one-cycle pulse; rx_data is valid this cycle.
REQ-008 rx_data  in  8  received UART byte.
REQ-009 restart  in  1  one-cycle pulse; aborts the current frame and rewinds to pixel 0.
REQ-010 wr_en  out  1  one-cycle BRAM port-A write strobe.
REQ-011 wr_addr  out  ADDR_W  BRAM write address, pixel index = line*IMG_W + column.
REQ-012 wr_data  out  24  pixel {R[7:0], G[7:0], B[7:0]}.
REQ-013 frame_done  out  1  one-cycle pulse coincident with the write of the last pixel.
REQ-014 frame_active  out  1  high from the first accepted byte of a frame until frame_done.
REQ-015 timeout_err  out  1  sticky flag; set when a partial pixel is discarded on timeout.

Function
REQ-016 The FSM SHALL have states WAIT_R, WAIT_G, WAIT_B; each rx_ready advances WAIT_R->WAIT_G->WAIT_B->WAIT_R.
REQ-017 The byte taken in WAIT_R SHALL go to wr_data[23:16], in WAIT_G to [15:8], in WAIT_B to [7:0].
REQ-018 wr_en SHALL assert exactly 1 clock after the rx_ready that completes a pixel, with wr_addr and wr_data stable during that cycle.
REQ-019 wr_addr SHALL increment by 1 in the cycle after each wr_en.
REQ-020 When the write is to address IMG_W*IMG_H-1, frame_done SHALL pulse with that wr_en, frame_active SHALL fall, and wr_addr SHALL then wrap to 0.
REQ-021 An idle counter SHALL clear on every rx_ready and count only in WAIT_G/WAIT_B.
REQ-022 When the idle counter reaches TIMEOUT_CYC, the FSM SHALL return to WAIT_R, discard the partial bytes, set timeout_err, and leave wr_addr unchanged.
REQ-023 A restart pulse SHALL force WAIT_R, wr_addr=0, frame_active=0, idle counter=0, and suppress any pending wr_en.
REQ-024 If restart coincides with rx_ready, restart SHALL win and the byte SHALL be dropped.
REQ-025 timeout_err SHALL clear only on reset or restart.
REQ-026 A new rx_ready arriving in the same cycle as wr_en SHALL be accepted normally.

Reset
REQ-027 While reset is high at a clk edge: state=WAIT_R, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_active=0, timeout_err=0, idle counter=0.
REQ-028 A reset mid-pixel or mid-frame SHALL discard all partial data; no write SHALL issue from pre-reset bytes.

Structure
REQ-029 The state enum and the default IMG_W/IMG_H constants SHALL live in shared package image_pkg, for use by the VGA read-address logic.
REQ-030 The address/wrap logic SHALL be one sub-module, pixel_addr_counter (enable, clear, wrap value, wrap pulse).

Verification
REQ-031 Bytes 0x12, 0x34, 0x56 from reset -> one wr_en, wr_addr=0, wr_data=0x123456, one cycle after the third rx_ready.
REQ-032 IMG_W=4, IMG_H=2, 8 pixels -> wr_addr 0..7; frame_done with the write to address 7; next pixel written to 0.
REQ-033 Two bytes, then TIMEOUT_CYC=16 idle cycles -> timeout_err=1, no wr_en; next three bytes written to the unchanged address.
REQ-034 Restart after 5 pixels plus 1 byte -> wr_addr=0, no write; next pixel written to 0 with correct R byte.
REQ-035 Restart and rx_ready in the same cycle -> byte dropped, state WAIT_R.
REQ-036 Reset asserted between the 2nd and 3rd byte -> all outputs at reset values; the 3rd byte is treated as an R byte.

Source files
------------

// File: rtl/image_pkg.sv
// Shared image geometry and receive-FSM state encoding.
// Also used by the VGA read-address logic.
package image_pkg;

    localparam int unsigned IMG_W_DEF = 512;
    localparam int unsigned IMG_H_DEF = 392;

    typedef enum logic [1:0] {
        WAIT_R = 2'd0,
        WAIT_G = 2'd1,
        WAIT_B = 2'd2
    } rx_state_t;

    function automatic int unsigned frame_pixels(
        input int unsigned w,
        input int unsigned h
    );
        return w * h;
    endfunction

endpackage

// File: rtl/pixel_addr_counter.sv
// Pixel write-address counter with clear and wrap-to-zero.
// at_wrap flags that the current address is the last in the frame.
module pixel_addr_counter #(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [ADDR_W-1:0] wrap_val,
    output logic [ADDR_W-1:0] count,
    output logic              at_wrap
);

    assign at_wrap = (count == wrap_val);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            if (at_wrap) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_rx_writer.sv
// Packs UART bytes into 24-bit RGB pixels and writes them to BRAM.
// Partial pixels are dropped on idle timeout, restart or reset.
module image_rx_writer
    import image_pkg::*;
#(
    parameter int IMG_W       = IMG_W_DEF,
    parameter int IMG_H       = IMG_H_DEF,
    parameter int ADDR_W      = 18,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_ready,
    input  logic [7:0]        rx_data,
    input  logic              restart,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              frame_done,
    output logic              frame_active,
    output logic              timeout_err
);

    localparam int unsigned PIX = frame_pixels(IMG_W, IMG_H);
    localparam logic [ADDR_W-1:0] WRAP_VAL = ADDR_W'(PIX - 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    rx_state_t         state;
    logic [7:0]        r_byte;
    logic [7:0]        g_byte;
    logic [IDLE_W-1:0] idle_cnt;
    logic              at_wrap;

    pixel_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk      (clk),
        .reset    (reset),
        .clear    (restart),
        .enable   (wr_en),
        .wrap_val (WRAP_VAL),
        .count    (wr_addr),
        .at_wrap  (at_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WAIT_R;
            r_byte       <= '0;
            g_byte       <= '0;
            idle_cnt     <= '0;
            wr_en        <= 1'b0;
            wr_data      <= '0;
            frame_done   <= 1'b0;
            frame_active <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (restart) begin
                state        <= WAIT_R;
                idle_cnt     <= '0;
                frame_active <= 1'b0;
                timeout_err  <= 1'b0;
            end else if (rx_ready) begin
                idle_cnt     <= '0;
                frame_active <= 1'b1;
                unique case (state)
                    WAIT_R: begin
                        r_byte <= rx_data;
                        state  <= WAIT_G;
                    end
                    WAIT_G: begin
                        g_byte <= rx_data;
                        state  <= WAIT_B;
                    end
                    WAIT_B: begin
                        wr_data <= {r_byte, g_byte, rx_data};
                        wr_en   <= 1'b1;
                        state   <= WAIT_R;
                        // address already points at the slot being written
                        if (at_wrap) begin
                            frame_done   <= 1'b1;
                            frame_active <= 1'b0;
                        end
                    end
                    default: state <= WAIT_R;
                endcase
            end else if (state != WAIT_R) begin
                if (idle_cnt == IDLE_LAST) begin
                    idle_cnt    <= '0;
                    state       <= WAIT_R;
                    timeout_err <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule
